// File: rtl/axis_bus_deserialiser.sv
// rtl/axis_bus_deserialiser.sv - packet-atomic one-into-two AXI-Stream demultiplexer
//
// Routes each whole packet from the single input stream to bus0 or bus1.
// The destination is taken from s_axis_tuser[P_ROUTE_BIT] on the packet's
// first beat. Each output has a one-stage register slice. The input only
// back-pressures on the slice that the current packet is going to.
//
// Optional feature: define AXIS_BUS_DESERIALISER_ERR_DROP_EN to discard
// packets whose first beat has s_axis_tuser[7]=1.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   en                     enable (asynchronous, synchronised internally)
//   s_axis_*               input stream (tdata/tkeep/tuser/tvalid/tlast, tready out)
//   m_axis_bus0_*          output stream 0 (tready in)
//   m_axis_bus1_*          output stream 1 (tready in)

`timescale 1ns/1ps

module axis_bus_deserialiser #(
  parameter int P_BUS_LENGTH = 8,
  parameter int P_ROUTE_BIT  = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      en,
  output logic                      s_axis_tready,
  input  logic [P_BUS_LENGTH-1:0]   s_axis_tdata,
  input  logic [P_BUS_LENGTH/8-1:0] s_axis_tkeep,
  input  logic [7:0]                s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic                      m_axis_bus0_tready,
  output logic [P_BUS_LENGTH-1:0]   m_axis_bus0_tdata,
  output logic [P_BUS_LENGTH/8-1:0] m_axis_bus0_tkeep,
  output logic [7:0]                m_axis_bus0_tuser,
  output logic                      m_axis_bus0_tvalid,
  output logic                      m_axis_bus0_tlast,
  input  logic                      m_axis_bus1_tready,
  output logic [P_BUS_LENGTH-1:0]   m_axis_bus1_tdata,
  output logic [P_BUS_LENGTH/8-1:0] m_axis_bus1_tkeep,
  output logic [7:0]                m_axis_bus1_tuser,
  output logic                      m_axis_bus1_tvalid,
  output logic                      m_axis_bus1_tlast
);

  localparam int KW = P_BUS_LENGTH / 8;

  typedef enum logic [1:0] {IDLE, PASS0, PASS1, DROP} state_t;

  state_t state, state_nxt;

  logic en_meta, en_s;
  logic ready;
  logic [1:0] sel;        // slice targeted by the beat on the input this cycle
  logic [1:0] wr;         // slice write strobes
  logic [1:0] slot_free;
  logic [1:0] m_ready;
  logic       route;
  logic       hs;

  logic [P_BUS_LENGTH-1:0] data_q  [2];
  logic [KW-1:0]           keep_q  [2];
  logic [7:0]              user_q  [2];
  logic [1:0]              valid_q;
  logic [1:0]              last_q;

  // Two-flop synchroniser for the asynchronous enable
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      en_meta <= en;
      en_s    <= en_meta;
    end
  end

  assign route     = s_axis_tuser[P_ROUTE_BIT];
  assign m_ready   = {m_axis_bus1_tready, m_axis_bus0_tready};
  assign slot_free = ~valid_q | m_ready;
  assign hs        = s_axis_tvalid & ready;
  assign wr        = sel & {2{hs}};

  // FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hs && !s_axis_tlast) begin
`ifdef AXIS_BUS_DESERIALISER_ERR_DROP_EN
          if (s_axis_tuser[7]) state_nxt = DROP;
          else
`endif
          state_nxt = route ? PASS1 : PASS0;
        end
      end
      default: begin
        if (hs && s_axis_tlast) state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs: input ready and destination select.
  // Only IDLE looks at en_s so a started packet is never truncated.
  always_comb begin
    ready = 1'b0;
    sel   = 2'b00;
    unique case (state)
      IDLE: begin
`ifdef AXIS_BUS_DESERIALISER_ERR_DROP_EN
        if (s_axis_tuser[7]) begin
          ready = en_s;
        end else
`endif
        begin
          ready = en_s & slot_free[route];
          sel   = route ? 2'b10 : 2'b01;
        end
      end
      PASS0: begin
        ready = slot_free[0];
        sel   = 2'b01;
      end
      PASS1: begin
        ready = slot_free[1];
        sel   = 2'b10;
      end
      default: ready = 1'b1;  // DROP: swallow beats, nothing written
    endcase
  end

  assign s_axis_tready = ready;

  // Output register slices
  for (genvar i = 0; i < 2; i++) begin : g_slice
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        valid_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
        data_q[i]  <= '0;
        keep_q[i]  <= '0;
        user_q[i]  <= '0;
      end else if (wr[i]) begin
        valid_q[i] <= 1'b1;
        last_q[i]  <= s_axis_tlast;
        data_q[i]  <= s_axis_tdata;
        keep_q[i]  <= s_axis_tkeep;
        user_q[i]  <= s_axis_tuser;
      end else if (m_ready[i]) begin
        valid_q[i] <= 1'b0;
      end
    end
  end

  assign m_axis_bus0_tdata  = data_q[0];
  assign m_axis_bus0_tkeep  = keep_q[0];
  assign m_axis_bus0_tuser  = user_q[0];
  assign m_axis_bus0_tvalid = valid_q[0];
  assign m_axis_bus0_tlast  = last_q[0];
  assign m_axis_bus1_tdata  = data_q[1];
  assign m_axis_bus1_tkeep  = keep_q[1];
  assign m_axis_bus1_tuser  = user_q[1];
  assign m_axis_bus1_tvalid = valid_q[1];
  assign m_axis_bus1_tlast  = last_q[1];

endmodule

// File: tb/tb_axis_bus_deserialiser.sv
// tb/tb_axis_bus_deserialiser.sv - directed self-checking bench for axis_bus_deserialiser

`timescale 1ns/1ps

module tb_axis_bus_deserialiser;

  localparam int W = 32;
  localparam int K = W / 8;

  typedef logic [W+K+8:0] beat_t;  // {tdata, tkeep, tuser, tlast}

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         en = 1'b0;
  logic         s_axis_tready;
  logic [W-1:0] s_axis_tdata = '0;
  logic [K-1:0] s_axis_tkeep = '0;
  logic [7:0]   s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         m0_tready = 1'b1;
  logic [W-1:0] m0_tdata;
  logic [K-1:0] m0_tkeep;
  logic [7:0]   m0_tuser;
  logic         m0_tvalid, m0_tlast;
  logic         m1_tready = 1'b1;
  logic [W-1:0] m1_tdata;
  logic [K-1:0] m1_tkeep;
  logic [7:0]   m1_tuser;
  logic         m1_tvalid, m1_tlast;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wait;
  int cy_a, cy_b;

  beat_t q0[$], q1[$];
  int    c0[$], c1[$];

  axis_bus_deserialiser #(.P_BUS_LENGTH(W), .P_ROUTE_BIT(0)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .en                 (en),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_bus0_tready (m0_tready),
    .m_axis_bus0_tdata  (m0_tdata),
    .m_axis_bus0_tkeep  (m0_tkeep),
    .m_axis_bus0_tuser  (m0_tuser),
    .m_axis_bus0_tvalid (m0_tvalid),
    .m_axis_bus0_tlast  (m0_tlast),
    .m_axis_bus1_tready (m1_tready),
    .m_axis_bus1_tdata  (m1_tdata),
    .m_axis_bus1_tkeep  (m1_tkeep),
    .m_axis_bus1_tuser  (m1_tuser),
    .m_axis_bus1_tvalid (m1_tvalid),
    .m_axis_bus1_tlast  (m1_tlast)
  );

  always #20 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitors: a beat seen valid&ready at the falling edge is taken at the next rising edge
  always @(negedge aclk) begin
    if (aresetn && m0_tvalid && m0_tready) begin
      q0.push_back({m0_tdata, m0_tkeep, m0_tuser, m0_tlast});
      c0.push_back(cyc);
    end
    if (aresetn && m1_tvalid && m1_tready) begin
      q1.push_back({m1_tdata, m1_tkeep, m1_tuser, m1_tlast});
      c1.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic [K-1:0] k,
                           input logic [7:0] u, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 64) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) check("send_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    last_wait = n;
  endtask

  task automatic idle_in();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic expect_beat(input int bus, input string tag, input logic [W-1:0] d,
                             input logic [K-1:0] k, input logic [7:0] u, input logic l,
                             output int cy);
    beat_t b;
    cy = -1;
    if (bus == 0) begin
      if (q0.size() == 0) begin check({tag, "_missing"}, 64'd0, 64'd1); return; end
      b  = q0.pop_front();
      cy = c0.pop_front();
    end else begin
      if (q1.size() == 0) begin check({tag, "_missing"}, 64'd0, 64'd1); return; end
      b  = q1.pop_front();
      cy = c1.pop_front();
    end
    check(tag, 64'(b), 64'({d, k, u, l}));
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); c0.delete(); c1.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cy;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m0_tvalid", m0_tvalid, 0);
    check("rst_m1_tvalid", m1_tvalid, 0);
    check("rst_m0_tlast", m0_tlast, 0);
    check("rst_m1_tdata", m1_tdata, 0);
    check("rst_m0_tuser", m0_tuser, 0);

    // Enable synchroniser latency
    @(posedge aclk); #1;
    aresetn = 1'b1;
    en      = 1'b1;
    @(negedge aclk);
    check("en_sync_0", s_axis_tready, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("en_sync_1", s_axis_tready, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("en_sync_2", s_axis_tready, 1);
    @(posedge aclk); #1;

    // 4-beat packet to bus0
    clear_q();
    send_beat(32'h11, 4'hF, 8'h00, 1'b0);
    check("t1_lat_tvalid", m0_tvalid, 1);
    check("t1_lat_tdata", m0_tdata, 32'h11);
    send_beat(32'h22, 4'hF, 8'h00, 1'b0);
    send_beat(32'h33, 4'hF, 8'h00, 1'b0);
    send_beat(32'h44, 4'hF, 8'h00, 1'b1);
    idle_in();
    settle(3);
    expect_beat(0, "t1_b1", 32'h11, 4'hF, 8'h00, 1'b0, cy_a);
    expect_beat(0, "t1_b2", 32'h22, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(0, "t1_b3", 32'h33, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(0, "t1_b4", 32'h44, 4'hF, 8'h00, 1'b1, cy_b);
    check("t1_throughput", 64'(cy_b - cy_a), 64'd3);
    check("t1_bus1_empty", q1.size(), 0);

    // bus1 packet then bus0 packet back-to-back; later-beat route bits ignored
    clear_q();
    send_beat(32'hA1, 4'h3, 8'h01, 1'b0);
    send_beat(32'hA2, 4'hF, 8'h00, 1'b0);
    send_beat(32'hA3, 4'h1, 8'h41, 1'b1);
    send_beat(32'hB1, 4'hC, 8'h00, 1'b0);
    send_beat(32'hB2, 4'hF, 8'h01, 1'b1);
    idle_in();
    settle(3);
    expect_beat(1, "t2_a1", 32'hA1, 4'h3, 8'h01, 1'b0, cy);
    expect_beat(1, "t2_a2", 32'hA2, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(1, "t2_a3", 32'hA3, 4'h1, 8'h41, 1'b1, cy_a);
    expect_beat(0, "t2_b1", 32'hB1, 4'hC, 8'h00, 1'b0, cy_b);
    expect_beat(0, "t2_b2", 32'hB2, 4'hF, 8'h01, 1'b1, cy);
    check("t2_no_gap", 64'(cy_b - cy_a), 64'd1);
    check("t2_q0_empty", q0.size(), 0);
    check("t2_q1_empty", q1.size(), 0);

    // Stall on bus1 for 5 cycles
    clear_q();
    m1_tready = 1'b0;
    send_beat(32'hC1, 4'hF, 8'h01, 1'b0);
    s_axis_tdata = 32'hC2;
    s_axis_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("t3_stall_ready", s_axis_tready, 0);
      check("t3_stall_m1_valid", m1_tvalid, 1);
      @(posedge aclk); #1;
    end
    check("t3_bus0_quiet", q0.size(), 0);
    m1_tready = 1'b1;
    send_beat(32'hC2, 4'hF, 8'h01, 1'b0);
    send_beat(32'hC3, 4'hF, 8'h01, 1'b1);
    idle_in();
    settle(3);
    expect_beat(1, "t3_c1", 32'hC1, 4'hF, 8'h01, 1'b0, cy);
    expect_beat(1, "t3_c2", 32'hC2, 4'hF, 8'h01, 1'b0, cy);
    expect_beat(1, "t3_c3", 32'hC3, 4'hF, 8'h01, 1'b1, cy);
    check("t3_q1_empty", q1.size(), 0);
    check("t3_q0_empty", q0.size(), 0);

    // en dropped mid-packet
    clear_q();
    send_beat(32'hD1, 4'hF, 8'h00, 1'b0);
    send_beat(32'hD2, 4'hF, 8'h00, 1'b0);
    en = 1'b0;
    send_beat(32'hD3, 4'hF, 8'h00, 1'b0);
    send_beat(32'hD4, 4'hF, 8'h00, 1'b1);
    s_axis_tdata = 32'h55;
    s_axis_tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("t4_stalled", s_axis_tready, 0);
      @(posedge aclk); #1;
    end
    en = 1'b1;
    @(negedge aclk);
    check("t4_resync", s_axis_tready, 0);
    @(posedge aclk); #1;
    send_beat(32'h55, 4'hF, 8'h00, 1'b1);
    idle_in();
    settle(3);
    expect_beat(0, "t4_d1", 32'hD1, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(0, "t4_d2", 32'hD2, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(0, "t4_d3", 32'hD3, 4'hF, 8'h00, 1'b0, cy);
    expect_beat(0, "t4_d4", 32'hD4, 4'hF, 8'h00, 1'b1, cy);
    expect_beat(0, "t4_next", 32'h55, 4'hF, 8'h00, 1'b1, cy);
    check("t4_q0_empty", q0.size(), 0);

    // Reset mid-packet
    clear_q();
    m1_tready = 1'b0;
    send_beat(32'hE1, 4'hF, 8'h01, 1'b0);
    s_axis_tdata = 32'h66;
    s_axis_tuser = 8'h00;
    s_axis_tlast = 1'b1;
    #5;
    aresetn = 1'b0;
    #1;
    check("t5_rst_m1_valid", m1_tvalid, 0);
    check("t5_rst_m1_data", m1_tdata, 0);
    check("t5_rst_m1_user", m1_tuser, 0);
    check("t5_rst_ready", s_axis_tready, 0);
    @(posedge aclk); #1;
    aresetn   = 1'b1;
    m1_tready = 1'b1;
    send_beat(32'h66, 4'hF, 8'h00, 1'b1);
    idle_in();
    settle(3);
    expect_beat(0, "t5_reroute", 32'h66, 4'hF, 8'h00, 1'b1, cy);
    check("t5_q1_empty", q1.size(), 0);

`ifdef AXIS_BUS_DESERIALISER_ERR_DROP_EN
    // Error packet discarded, following packet forwarded
    clear_q();
    send_beat(32'hF1, 4'hF, 8'h80, 1'b0);
    check("t6_drop_w1", last_wait, 0);
    send_beat(32'hF2, 4'hF, 8'h01, 1'b0);
    check("t6_drop_w2", last_wait, 0);
    send_beat(32'hF3, 4'hF, 8'h80, 1'b1);
    check("t6_drop_w3", last_wait, 0);
    check("t6_no_m0", m0_tvalid, 0);
    check("t6_no_m1", m1_tvalid, 0);
    send_beat(32'h71, 4'hF, 8'h01, 1'b0);
    send_beat(32'h72, 4'hF, 8'h01, 1'b1);
    idle_in();
    settle(3);
    expect_beat(1, "t6_g1", 32'h71, 4'hF, 8'h01, 1'b0, cy);
    expect_beat(1, "t6_g2", 32'h72, 4'hF, 8'h01, 1'b1, cy);
    check("t6_q1_empty", q1.size(), 0);
    check("t6_q0_empty", q0.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
